// File: rtl/wake_ctrl.sv
`default_nettype none
// ============================================================================
// Module : wake_ctrl
// Desc   : Keyword-hit debouncer driving a wake line with sustain/cooldown.
//          Define WAKE_CTRL_COUNT_EN to add the saturating wake_count_o port.
// Rev    : 1.0  initial release
// ============================================================================
module wake_ctrl #(
    parameter int NUM_CLASSES = 3,
    parameter int KEYWORD_IDX = 0,
    parameter int HITS_BW     = 4,
    parameter int SUSTAIN_BW  = 16,
    parameter int COOLDOWN_BW = 16,
    parameter int GAP_TIMEOUT = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_CLASSES-1:0] data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic                   ready_o,
    input  logic [HITS_BW-1:0]     cfg_hits_i,
    input  logic [SUSTAIN_BW-1:0]  cfg_sustain_i,
    input  logic [COOLDOWN_BW-1:0] cfg_cooldown_i,
    output logic                   wake_o,
    output logic                   wake_pulse_o,
`ifdef WAKE_CTRL_COUNT_EN
    output logic [7:0]             wake_count_o,
`endif
    output logic [1:0]             state_o
);

    localparam int                     GAP_BW   = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [GAP_BW-1:0]      GAP_LAST = GAP_BW'(GAP_TIMEOUT - 1);
    localparam logic [GAP_BW-1:0]      GAP_ONE  = 1;
    localparam logic [HITS_BW-1:0]     HITS_ONE = 1;
    localparam logic [HITS_BW:0]       HIT_INC  = 1;
    localparam logic [SUSTAIN_BW-1:0]  SUS_ONE  = 1;
    localparam logic [COOLDOWN_BW-1:0] COOL_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_WAKE     = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    state_t                 r_state;
    logic [HITS_BW-1:0]     r_hits;
    logic [HITS_BW-1:0]     r_hit_cnt;
    logic [GAP_BW-1:0]      r_gap_cnt;
    logic [SUSTAIN_BW-1:0]  r_sustain_cnt;
    logic [COOLDOWN_BW-1:0] r_cooldown;
    logic [COOLDOWN_BW-1:0] r_cool_cnt;

    logic                   w_accept;
    logic                   w_hit;
    logic                   w_enter_wake;
    logic                   w_unused_data;
    logic [HITS_BW-1:0]     w_eff_hits;
    logic [HITS_BW:0]       w_hit_next;
    logic [SUSTAIN_BW-1:0]  w_sustain_m1;

    assign w_accept      = valid_i && ready_o;
    assign w_hit         = w_accept && data_i[KEYWORD_IDX];
    assign w_unused_data = ^data_i;
    assign w_eff_hits    = (cfg_hits_i == '0) ? HITS_ONE : cfg_hits_i;
    assign w_hit_next    = {1'b0, r_hit_cnt} + HIT_INC;
    assign w_sustain_m1  = (cfg_sustain_i == '0) ? '0 : (cfg_sustain_i - SUS_ONE);

    // A threshold-completing hit is handled ahead of the per-state logic.
    assign w_enter_wake  = w_hit &&
                           (((r_state == ST_IDLE) && (w_eff_hits == HITS_ONE)) ||
                            ((r_state == ST_ARM)  && (w_hit_next == {1'b0, r_hits})));

    assign state_o = r_state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_hits        <= '0;
            r_hit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_sustain_cnt <= '0;
            r_cooldown    <= '0;
            r_cool_cnt    <= '0;
            ready_o       <= 1'b0;
            wake_o        <= 1'b0;
            wake_pulse_o  <= 1'b0;
        end else begin
            ready_o      <= 1'b1;
            wake_pulse_o <= 1'b0;
            if (w_enter_wake) begin
                if (r_state == ST_IDLE) begin
                    r_hits <= w_eff_hits;
                end
                r_state       <= ST_WAKE;
                r_hit_cnt     <= '0;
                r_gap_cnt     <= '0;
                r_sustain_cnt <= w_sustain_m1;
                r_cooldown    <= cfg_cooldown_i;
                wake_o        <= 1'b1;
                wake_pulse_o  <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_hit && !last_i) begin
                            r_state   <= ST_ARM;
                            r_hits    <= w_eff_hits;
                            r_hit_cnt <= HITS_ONE;
                            r_gap_cnt <= '0;
                        end
                    end
                    ST_ARM: begin
                        if (w_accept) begin
                            r_gap_cnt <= '0;
                            if (w_hit && !last_i) begin
                                r_hit_cnt <= w_hit_next[HITS_BW-1:0];
                            end else begin
                                r_state   <= ST_IDLE;
                                r_hit_cnt <= '0;
                            end
                        end else if (r_gap_cnt == GAP_LAST) begin
                            r_state   <= ST_IDLE;
                            r_hit_cnt <= '0;
                            r_gap_cnt <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GAP_ONE;
                        end
                    end
                    ST_WAKE: begin
                        if (r_sustain_cnt == '0) begin
                            wake_o <= 1'b0;
                            if (r_cooldown != '0) begin
                                r_state    <= ST_COOLDOWN;
                                r_cool_cnt <= r_cooldown - COOL_ONE;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_sustain_cnt <= r_sustain_cnt - SUS_ONE;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (r_cool_cnt == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cool_cnt <= r_cool_cnt - COOL_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef WAKE_CTRL_COUNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wake_count_o <= 8'd0;
        end else if (w_enter_wake && (wake_count_o != 8'hFF)) begin
            wake_count_o <= wake_count_o + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wake_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_wake_ctrl
// Desc   : Scoreboard bench for wake_ctrl against a timestamp-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wake_ctrl;

    localparam int NC = 3;
    localparam int KW = 0;
    localparam int HB = 4;
    localparam int SB = 16;
    localparam int CB = 16;
    localparam int GT = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          last;
    logic [NC-1:0] data;
    logic [HB-1:0] cfg_hits;
    logic [SB-1:0] cfg_sus;
    logic [CB-1:0] cfg_cool;
    logic          ready;
    logic          wake;
    logic          pulse;
    logic [1:0]    state;
`ifdef WAKE_CTRL_COUNT_EN
    logic [7:0]    wcount;
`endif

    always #5 clk = ~clk;

    wake_ctrl #(
        .NUM_CLASSES (NC),
        .KEYWORD_IDX (KW),
        .HITS_BW     (HB),
        .SUSTAIN_BW  (SB),
        .COOLDOWN_BW (CB),
        .GAP_TIMEOUT (GT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_i         (data),
        .valid_i        (valid),
        .last_i         (last),
        .ready_o        (ready),
        .cfg_hits_i     (cfg_hits),
        .cfg_sustain_i  (cfg_sus),
        .cfg_cooldown_i (cfg_cool),
        .wake_o         (wake),
        .wake_pulse_o   (pulse),
`ifdef WAKE_CTRL_COUNT_EN
        .wake_count_o   (wcount),
`endif
        .state_o        (state)
    );

    typedef struct {
        logic [4:0] vec;   // {ready, wake, pulse, state[1:0]}
        int         cnt;
        longint     cyc;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Reference model: wake/cooldown windows kept as absolute cycle stamps.
    longint cyc    = 0;
    bit     m_ready = 1'b0;
    int     m_run  = 0;
    int     m_need = 1;
    int     m_idle = 0;
    int     m_cnt  = 0;
    longint m_ws   = -1;
    longint m_we   = 0;
    longint m_ce   = 0;

    function automatic int phase(input longint c);
        if (c < m_we) return 2;
        if (c < m_ce) return 3;
        if (m_run > 0) return 1;
        return 0;
    endfunction

    task automatic start_wake();
        int s;
        s      = (cfg_sus == 0) ? 1 : int'(cfg_sus);
        m_ws   = cyc + 1;
        m_we   = cyc + 1 + s;
        m_ce   = m_we + longint'(cfg_cool);
        m_run  = 0;
        m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
    endtask

    task automatic model_step();
        int   ph;
        int   nph;
        bit   acc;
        bit   hit;
        exp_t e;
        ph  = phase(cyc);
        acc = valid && m_ready;
        hit = acc && data[KW];
        if (rst) begin
            m_ready = 1'b0;
            m_run   = 0;
            m_idle  = 0;
            m_cnt   = 0;
            m_ws    = -1;
            m_we    = 0;
            m_ce    = 0;
        end else begin
            if (ph == 0) begin
                if (hit) begin
                    m_need = (cfg_hits == 0) ? 1 : int'(cfg_hits);
                    if (m_need == 1) start_wake();
                    else if (!last) begin
                        m_run  = 1;
                        m_idle = 0;
                    end
                end
            end else if (ph == 1) begin
                if (acc) begin
                    m_idle = 0;
                    if (hit) begin
                        m_run++;
                        if (m_run == m_need) start_wake();
                        else if (last) m_run = 0;
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == GT) m_run = 0;
                end
            end
            m_ready = 1'b1;
        end
        nph   = phase(cyc + 1);
        e.vec = {m_ready, (nph == 2), (nph == 2) && (m_ws == cyc + 1), nph[1:0]};
        e.cnt = m_cnt;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit v, input bit h, input bit l);
        rst     = r;
        valid   = v;
        data    = NC'($urandom);
        data[KW] = h;
        last    = l;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_cfg(input int h, input int s, input int c);
        cfg_hits = HB'(h);
        cfg_sus  = SB'(s);
        cfg_cool = CB'(c);
    endtask

    // Monitor: compares every presented output cycle against the scoreboard.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if ({ready, wake, pulse, state} !== e.vec) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d: got ready/wake/pulse/state=%b required %b",
                         e.cyc, {ready, wake, pulse, state}, e.vec);
            end
`ifdef WAKE_CTRL_COUNT_EN
            n_checks++;
            if (wcount !== 8'(e.cnt)) begin
                n_fail++;
                $display("FAIL wake_count cyc=%0d: got %0d required %0d", e.cyc, wcount, e.cnt);
            end
`endif
        end
    end

    initial begin
        set_cfg(3, 10, 5);
        rst = 1'b1; valid = 1'b0; last = 1'b0; data = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Three consecutive hits with sustain/cooldown
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(20);

        // Broken runs: non-hit, then early last
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);
        drive(1'b0, 1'b1, 1'b1, 1'b1);   // last on first hit stays idle
        idle(2);

        // Gap timeout versus a gap just short of it
        set_cfg(2, 3, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(GT);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(GT - 2);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        idle(6);

        // Continuous hits through wake and cooldown
        set_cfg(1, 4, 3);
        repeat (24) drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // All-zero configuration
        set_cfg(0, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(4);

        // Reset during the second wake cycle
        set_cfg(1, 10, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);

`ifdef WAKE_CTRL_COUNT_EN
        set_cfg(1, 1, 0);
        repeat (620) drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
`endif

        // Randomized traffic with mid-sequence config changes
        set_cfg(2, 3, 2);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 3)
                set_cfg($urandom_range(4), $urandom_range(6), $urandom_range(4));
            if ($urandom_range(999) < 5) begin
                drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            end else if ($urandom_range(999) < 8) begin
                idle($urandom_range(GT + 40, GT - 40));
            end else begin
                drive(1'b0, ($urandom_range(99) < 70), ($urandom_range(99) < 65),
                      ($urandom_range(99) < 15));
            end
        end
        idle(30);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
